limb_multiplier: RTL and testbench
==================================

LIMB_MULTIPLIER -- requirements
Module: limb_multiplier

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits; SHALL be a multiple of LIMB and at least 2*LIMB.
REQ-002 Parameter LIMB, default 16, limb width in bits; one LIMB x LIMB partial product is consumed per cycle.
REQ-003 CLK  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  request; SHALL be sampled only while in IDLE.
REQ-006 A  input  WIDTH  unsigned multiplicand; SHALL be sampled together with START.
REQ-007 B  input  WIDTH  unsigned multiplier; SHALL be sampled together with START.
REQ-008 BUSY  output  1  high while not in IDLE.
REQ-009 DONE  output  1  single-cycle pulse; P is valid in this cycle.
REQ-010 P  output  2*WIDTH  unsigned product A*B; SHALL hold its value until the next DONE.

Function
REQ-011 N = WIDTH/LIMB; the block SHALL have states IDLE, MUL and FIN.
REQ-012 IDLE with START=1 at a rising edge SHALL latch A and B, clear the accumulator and counters, and go to MUL.
REQ-013 MUL SHALL run exactly N*N cycles, with index i (limb of A) outer and j (limb of B) inner, both counting 0..N-1.
REQ-014 Each MUL cycle SHALL add a_i*b_j, shifted left by (i+j)*LIMB, into a 2*WIDTH accumulator; no carry may be lost.
REQ-015 At i=j=N-1, MUL SHALL go to FIN; FIN SHALL load P from the accumulator, pulse DONE for one cycle, and return to IDLE.
REQ-016 Latency SHALL be fixed: DONE is high in the cycle starting N*N+1 edges after the START-sampling edge (17 for WIDTH=64).
REQ-017 START in MUL or FIN SHALL be ignored; the operation in flight and the latched operands SHALL be unaffected.
REQ-018 START may be asserted in the cycle after DONE; back-to-back operations SHALL give one result every N*N+2 cycles.
REQ-019 Changes on A or B after the START-sampling edge SHALL have no effect on the result.
REQ-020 Arithmetic SHALL be unsigned; no overflow is possible because the full 2*WIDTH product is kept.

Reset
REQ-021 RST=1 SHALL force IDLE immediately, regardless of CLK, from any state including mid-MUL.
REQ-022 Reset values: BUSY=0, DONE=0, P=0; accumulator, counters and operand registers = 0.
REQ-023 An aborted operation SHALL produce no DONE; P SHALL read 0 after reset.

Configuration
REQ-024 Macro LIMB_MULTIPLIER_PIPE_EN: when defined, the limb product SHALL be registered before accumulation, and MUL SHALL last N*N+1 cycles. This gives a latency of N*N+2 and a back-to-back period of N*N+3.
REQ-025 Without LIMB_MULTIPLIER_PIPE_EN, the limb product SHALL feed the accumulator combinationally, with the latency stated in REQ-016.
REQ-026 Results SHALL be identical in both builds; only timing differs.

Structure
REQ-027 Package limb_mult_pkg SHALL hold the state enum (IDLE, MUL, FIN) and the default WIDTH and LIMB constants.
REQ-028 Sub-module mult_limb SHALL compute the LIMB x LIMB unsigned product; it SHALL contain the output register when LIMB_MULTIPLIER_PIPE_EN is defined.
REQ-029 Counters SHALL be $clog2(N) bits wide; the shift offset SHALL be derived from i+j, not stored.

Verification
REQ-030 Max operands, WIDTH=64: A=B=2^64-1 -> P=0xFFFFFFFFFFFFFFFE0000000000000001, DONE 17 cycles after START, BUSY high for 17 cycles.
REQ-031 Identity and zero: A=1, B=0x0123456789ABCDEF -> P=0x0123456789ABCDEF. Then A=0, B=2^64-1 -> P=0.
REQ-032 Ignored START: pulse START with A=3,B=5, then START again 4 cycles later with A=7,B=7 -> exactly one DONE with P=15. The second request SHALL be dropped.
REQ-033 Reset mid-operation: assert RST 8 cycles into MUL -> BUSY=0 and P=0 at once, no DONE. A new START with A=2,B=3 -> P=6.
REQ-034 Back-to-back and random: 1000 random operand pairs at WIDTH=32, LIMB=16 with START the cycle after each DONE. Every P SHALL match the reference A*B, with period 6. Repeat with LIMB_MULTIPLIER_PIPE_EN: period 7, same results.

Source files
------------

// File: rtl/limb_mult_pkg.sv
// Shared types and default sizing for the limb-serial multiplier.
package limb_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_LIMB  = 16;

endpackage

// File: rtl/mult_limb.sv
// LIMB x LIMB unsigned multiplier; with LIMB_MULTIPLIER_PIPE_EN defined the
// product is registered, otherwise it is purely combinational.
module mult_limb #(
    parameter int LIMB = 16
) (
`ifdef LIMB_MULTIPLIER_PIPE_EN
    input  logic              clk_i,
    input  logic              rst_i,
`endif
    input  logic [LIMB-1:0]   a_i,
    input  logic [LIMB-1:0]   b_i,
    output logic [2*LIMB-1:0] p_o
);

    localparam int PW = 2 * LIMB;

`ifdef LIMB_MULTIPLIER_PIPE_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_o <= '0;
        end else begin
            p_o <= PW'(a_i) * PW'(b_i);
        end
    end
`else
    assign p_o = PW'(a_i) * PW'(b_i);
`endif

endmodule

// File: rtl/limb_multiplier.sv
// Multi-cycle unsigned WIDTH x WIDTH multiplier, one limb product per cycle.
// Define LIMB_MULTIPLIER_PIPE_EN to register the limb product (one extra MUL cycle).
module limb_multiplier
    import limb_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMB  = DEF_LIMB
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] P,
    output state_t             DBG_STATE
);

    localparam int N  = WIDTH / LIMB;
    localparam int IW = $clog2(N);
    localparam int PW = 2 * WIDTH;
    localparam int SW = $clog2(PW);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     acc_q, acc_d, p_q, prod_sh;
    logic [IW-1:0]     i_q, j_q;
    logic              done_q;
    logic [LIMB-1:0]   a_limb, b_limb;
    logic [2*LIMB-1:0] prod;
    logic [IW:0]       ij;
    logic [SW-1:0]     shamt;
    logic              add_en;
    logic              last_issue;

    assign a_limb     = a_q[i_q*LIMB +: LIMB];
    assign b_limb     = b_q[j_q*LIMB +: LIMB];
    assign last_issue = (i_q == LAST) && (j_q == LAST);

    mult_limb #(.LIMB(LIMB)) u_mult (
`ifdef LIMB_MULTIPLIER_PIPE_EN
        .clk_i (CLK),
        .rst_i (RST),
`endif
        .a_i   (a_limb),
        .b_i   (b_limb),
        .p_o   (prod)
    );

`ifdef LIMB_MULTIPLIER_PIPE_EN
    // The product lands one cycle after issue, so its limb indices trail too.
    logic [IW-1:0] ip_q, jp_q;
    logic          pv_q, drain_q;
    assign ij     = {1'b0, ip_q} + {1'b0, jp_q};
    assign add_en = pv_q;
`else
    assign ij     = {1'b0, i_q} + {1'b0, j_q};
    assign add_en = (state_q == MUL);
`endif

    assign shamt   = SW'(ij * LIMB);
    assign prod_sh = {{(PW - 2*LIMB){1'b0}}, prod} << shamt;

    always_comb begin
        acc_d = acc_q;
        if (add_en) begin
            acc_d = acc_q + prod_sh;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
`ifdef LIMB_MULTIPLIER_PIPE_EN
            ip_q    <= '0;
            jp_q    <= '0;
            pv_q    <= 1'b0;
            drain_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef LIMB_MULTIPLIER_PIPE_EN
            pv_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= B;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        state_q <= MUL;
`ifdef LIMB_MULTIPLIER_PIPE_EN
                        drain_q <= 1'b0;
`endif
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
`ifdef LIMB_MULTIPLIER_PIPE_EN
                    if (drain_q) begin
                        state_q <= FIN;
                    end else begin
                        ip_q <= i_q;
                        jp_q <= j_q;
                        pv_q <= 1'b1;
                        if (last_issue) begin
                            drain_q <= 1'b1;
                        end else if (j_q == LAST) begin
                            j_q <= '0;
                            i_q <= i_q + 1'b1;
                        end else begin
                            j_q <= j_q + 1'b1;
                        end
                    end
`else
                    if (last_issue) begin
                        state_q <= FIN;
                    end else if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
`endif
                end
                FIN: begin
                    p_q     <= acc_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign P         = p_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_limb_multiplier.sv
// Directed bench for limb_multiplier at WIDTH=64 and WIDTH=32 (LIMB=16).
module tb_limb_multiplier;
    import limb_mult_pkg::*;

`ifdef LIMB_MULTIPLIER_PIPE_EN
    localparam int LAT64 = 18;
    localparam int LAT32 = 6;
`else
    localparam int LAT64 = 17;
    localparam int LAT32 = 5;
`endif
    localparam int PER32 = LAT32 + 1;

    logic         clk;
    logic         rst;
    logic         start64, start32;
    logic [63:0]  a64, b64;
    logic [31:0]  a32, b32;
    logic         busy64, done64, busy32, done32;
    logic [127:0] p64;
    logic [63:0]  p32;
    state_t       dbg64, dbg32;

    int n_vec;
    int n_err;
    int cyc;
    logic [63:0] exp_q[$];

    limb_multiplier #(.WIDTH(64), .LIMB(16)) u_dut64 (
        .CLK(clk), .RST(rst), .START(start64), .A(a64), .B(b64),
        .BUSY(busy64), .DONE(done64), .P(p64), .DBG_STATE(dbg64)
    );

    limb_multiplier #(.WIDTH(32), .LIMB(16)) u_dut32 (
        .CLK(clk), .RST(rst), .START(start32), .A(a32), .B(b32),
        .BUSY(busy32), .DONE(done32), .P(p32), .DBG_STATE(dbg32)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one 64-bit operation and wait for DONE; lat=-1 on timeout.
    task automatic run64(input logic [63:0] a, input logic [63:0] b,
                         output logic [127:0] p, output int lat, output int busy_cnt);
        a64 = a;
        b64 = b;
        start64 = 1'b1;
        tick();
        start64 = 1'b0;
        a64 = ~a;
        b64 = ~b;
        lat = -1;
        busy_cnt = 0;
        p = '0;
        for (int c = 1; c <= 40; c++) begin
            if (busy64) busy_cnt++;
            tick();
            if (done64) begin
                lat = c;
                p = p64;
                break;
            end
        end
    endtask

    initial begin
        logic [127:0] p;
        logic [127:0] p_seen;
        int lat, busy_cnt, dones, start_prev, start_now;
        logic [31:0] ra, rb;
        logic [63:0] expv;

        n_vec = 0;
        n_err = 0;
        cyc = 0;
        rst = 1'b1;
        start64 = 1'b0;
        start32 = 1'b0;
        a64 = '0; b64 = '0; a32 = '0; b32 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset_busy", 128'(busy64), 128'(0));
        check("reset_done", 128'(done64), 128'(0));
        check("reset_p", p64, 128'(0));
        check("reset_state", 128'(dbg64), 128'(IDLE));

        // max operands
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, p, lat, busy_cnt);
        check("max_p", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        check("max_latency", 128'(lat), 128'(LAT64));
        check("max_busy_cycles", 128'(busy_cnt), 128'(LAT64));
        tick();
        check("done_single_pulse", 128'(done64), 128'(0));
        check("p_held", p64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // identity and zero
        run64(64'd1, 64'h0123_4567_89AB_CDEF, p, lat, busy_cnt);
        check("identity_p", p, 128'h0123_4567_89AB_CDEF);
        run64(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, p, lat, busy_cnt);
        check("zero_p", p, 128'd0);
        run64(64'h1_0000_0000, 64'h1_0000_0001, p, lat, busy_cnt);
        check("cross_limb_p", p, 128'h1_0000_0001_0000_0000);

        // START while busy is dropped
        a64 = 64'd3; b64 = 64'd5; start64 = 1'b1;
        tick();
        start64 = 1'b0; a64 = 64'hDEAD; b64 = 64'hBEEF;
        repeat (3) tick();
        a64 = 64'd7; b64 = 64'd7; start64 = 1'b1;
        tick();
        start64 = 1'b0; a64 = 64'h1234; b64 = 64'h5678;
        dones = 0;
        p_seen = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done64) begin
                dones++;
                p_seen = p64;
            end
        end
        check("ignored_start_dones", 128'(dones), 128'(1));
        check("ignored_start_p", p_seen, 128'd15);

        // reset in the middle of MUL
        a64 = 64'd9; b64 = 64'd9; start64 = 1'b1;
        tick();
        start64 = 1'b0;
        repeat (8) tick();
        check("pre_reset_busy", 128'(busy64), 128'(1));
        rst = 1'b1;
        #1;
        check("abort_busy", 128'(busy64), 128'(0));
        check("abort_p", p64, 128'd0);
        check("abort_state", 128'(dbg64), 128'(IDLE));
        #1;
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done64) dones++;
        end
        check("abort_no_done", 128'(dones), 128'(0));
        run64(64'd2, 64'd3, p, lat, busy_cnt);
        check("after_abort_p", p, 128'd6);

        // 32-bit back-to-back: directed corner then random pairs
        start_prev = -1;
        for (int k = 0; k < 1001; k++) begin
            if (k == 0) begin
                ra = 32'hFFFF_FFFF;
                rb = 32'hFFFF_FFFF;
                expv = 64'hFFFF_FFFE_0000_0001;
            end else begin
                ra = $urandom;
                rb = $urandom_range(32'hFFFF_FFFF, 0);
                expv = 64'(ra) * 64'(rb);
            end
            exp_q.push_back(expv);
            a32 = ra;
            b32 = rb;
            start32 = 1'b1;
            tick();
            start_now = cyc;
            start32 = 1'b0;
            a32 = ~ra;
            b32 = ~rb;
            if (start_prev >= 0) check("b2b_period", 128'(start_now - start_prev), 128'(PER32));
            start_prev = start_now;
            lat = -1;
            for (int c = 1; c <= 20; c++) begin
                tick();
                if (done32) begin
                    lat = c;
                    break;
                end
            end
            if (lat < 0) begin
                check("b2b_done_timeout", 128'(lat), 128'(LAT32));
                void'(exp_q.pop_front());
                break;
            end
            check("b2b_p", 128'(p32), 128'(exp_q.pop_front()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
